// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding and counter sizing helper.
package serial_add_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..WIDTH, so it needs clog2(WIDTH+1) bits.
   function automatic int cnt_width(input int w);
      return (w < 1) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
// Shared datapath element of the serial adder.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic co,
   output logic s
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, one bit per clock.
// LSB first, start/busy/done handshake toward the requester.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum_nx;

   fa u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_carry),
      .co (w_co),
      .s  (w_s)
   );

   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   // New bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
   assign w_sum_nx = WIDTH'({w_s, r_sum} >> 1);

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = start ? RUN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_carry <= w_co;
            r_sum   <= w_sum_nx;
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_co;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
